// File: rtl/alu_defs.sv
// Shared opcode constants and FSM state encoding for the ALU issue unit.
package alu_defs;

    // ALU opcodes as driven on alu_op
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;

    // Highest legal command opcode; 6 and 7 are flagged as errors
    localparam logic [2:0] OP_MAX_LEGAL = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by the issue unit.
module alu
    import alu_defs::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alu_op,
    output logic [DATA_W-1:0] result
);

    // Opcode decode; unknown opcodes produce zero
    always_comb begin
        result = '0;
        case (alu_op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// Register file: three combinational read ports, one synchronous write port, r0 reads as zero.
module alu_regfile #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    output logic [DATA_W-1:0]     rs_data,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rt_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage: async clear of every entry, writes to r0 dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read ports; r0 forced to zero regardless of storage contents
    always_comb begin
        rs_data  = (rs_addr == '0) ? '0 : regs_q[rs_addr];
        rt_data  = (rt_addr == '0) ? '0 : regs_q[rt_addr];
        dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Operand fetch / issue stage for the combinational alu: one command in flight,
// IDLE -> EXEC -> RESP, result written back at the end of EXEC.
module alu_issue_unit
    import alu_defs::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_rd,
    input  logic [REG_ADDR_W-1:0] cmd_rs,
    input  logic [REG_ADDR_W-1:0] cmd_rt,
    input  logic                  cmd_imm_en,
    input  logic [IMM_W-1:0]      cmd_imm,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [3:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_ADDR_W-1:0] rsp_rd,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     alu_a_q, alu_b_q;
    logic [3:0]            alu_op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  err_q;
    logic                  rsp_valid_q;
    logic [REG_ADDR_W-1:0] rsp_rd_q;
    logic [DATA_W-1:0]     rsp_data_q;
    logic                  rsp_err_q;

    logic [DATA_W-1:0]     rs_data, rt_data;
    logic [DATA_W-1:0]     imm_sext;
    logic                  accept, complete, rsp_fire;
    logic                  wr_en;

    assign imm_sext = {{(DATA_W - IMM_W){cmd_imm[IMM_W-1]}}, cmd_imm};

    // Handshake qualifiers per state; ready gated low while reset is held
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && rst_n;
        accept    = (state_q == ST_IDLE) && cmd_valid;
        complete  = (state_q == ST_EXEC);
        rsp_fire  = (state_q == ST_RESP) && rsp_ready;
        wr_en     = complete && !err_q;
    end

    alu_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (cmd_rs),
        .rs_data  (rs_data),
        .rt_addr  (cmd_rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (rd_q),
        .wr_data  (alu_result)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/opcode capture on accept; values persist until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 4'b0000;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            alu_a_q  <= rs_data;
            alu_b_q  <= cmd_imm_en ? imm_sext : rt_data;
            alu_op_q <= {1'b0, cmd_op};
            rd_q     <= cmd_rd;
            err_q    <= (cmd_op > OP_MAX_LEGAL);
        end
    end

    // Response payload: loaded at end of EXEC, held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rd_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (complete) begin
            rsp_rd_q   <= rd_q;
            rsp_data_q <= err_q ? '0 : alu_result;
            rsp_err_q  <= err_q;
        end
    end

    // Response valid: set on completion, cleared by the consumer handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
        end else if (complete) begin
            rsp_valid_q <= 1'b1;
        end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit wired to alu.
module tb_alu_issue_unit;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs;
    logic [2:0]  cmd_rt;
    logic        cmd_imm_en;
    logic [15:0] cmd_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_cmp;
    int n_bad;

    alu_issue_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rd     (rsp_rd),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Issue one command with rsp_ready=1; checks accept, 2-edge latency and payload.
    task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt, input logic imm_en,
                         input logic [15:0] imm, input logic [31:0] exp_data,
                         input logic exp_err);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_rd     = rd;
        cmd_rs     = rs;
        cmd_rt     = rt;
        cmd_imm_en = imm_en;
        cmd_imm    = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".data"}, rsp_data, exp_data);
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, ".rd"}, 32'(rsp_rd), 32'(rd));
        @(posedge clk);
        #1;
        check({tag, ".done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held_data;
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_rd     = 3'd0;
        cmd_rs     = 3'd0;
        cmd_rt     = 3'd0;
        cmd_imm_en = 1'b0;
        cmd_imm    = 16'h0;
        rsp_ready  = 1'b1;
        dbg_addr   = 3'd0;

        // Reset state
        #12;
        check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_data", rsp_data, 32'h0);
        check("rst.alu_op", 32'(alu_op), 32'h0);
        check("rst.alu_a", alu_a, 32'h0);
        check_reg("rst.r1", 3'd1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle.cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: immediate sign extension
        issue("t1.add_7fff", 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 32'h0000_7FFF, 1'b0);
        issue("t1.add_8000", 3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h8000, 32'hFFFF_8000, 1'b0);
        check_reg("t1.r1", 3'd1, 32'h0000_7FFF);
        check_reg("t1.r2", 3'd2, 32'hFFFF_8000);

        // 2: dependent back-to-back commands
        issue("t2.r1", 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h000F, 32'h0000_000F, 1'b0);
        issue("t2.r2", 3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001, 32'h0000_0001, 1'b0);
        issue("t2.sub", 3'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 32'h0000_000E, 1'b0);
        issue("t2.xor", 3'd4, 3'd4, 3'd3, 3'd1, 1'b0, 16'h0, 32'h0000_0001, 1'b0);
        check_reg("t2.r4", 3'd4, 32'h0000_0001);

        // 3: build r6=00FF00FF by doubling, r5=~r6, then logic ops
        issue("t3.seed", 3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00FF, 32'h0000_00FF, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            issue("t3.dbl", 3'd0, 3'd6, 3'd6, 3'd6, 1'b0, 16'h0, 32'h0000_00FF << i, 1'b0);
        end
        issue("t3.lo", 3'd0, 3'd6, 3'd6, 3'd0, 1'b1, 16'h00FF, 32'h00FF_00FF, 1'b0);
        issue("t3.r5", 3'd5, 3'd5, 3'd6, 3'd6, 1'b0, 16'h0, 32'hFF00_FF00, 1'b0);
        issue("t3.or", 3'd3, 3'd7, 3'd5, 3'd6, 1'b0, 16'h0, 32'hFFFF_FFFF, 1'b0);
        issue("t3.nor", 3'd5, 3'd7, 3'd5, 3'd6, 1'b0, 16'h0, 32'h0000_0000, 1'b0);
        issue("t3.and", 3'd2, 3'd7, 3'd5, 3'd6, 1'b0, 16'h0, 32'h0000_0000, 1'b0);
        check("t3.alu_op_hold", 32'(alu_op), 32'h2);
        check("t3.alu_a_hold", alu_a, 32'hFF00_FF00);

        // 4: illegal opcode and r0 destination
        issue("t4.illegal", 3'd6, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0, 32'h0, 1'b1);
        check_reg("t4.r1", 3'd1, 32'h0000_000F);
        issue("t4.r0", 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0005, 32'h0000_0005, 1'b0);
        check_reg("t4.r0_zero", 3'd0, 32'h0);

        // 5: back-pressure on the response
        rsp_ready  = 1'b0;
        cmd_valid  = 1'b1;
        cmd_op     = 3'd0;
        cmd_rd     = 3'd2;
        cmd_rs     = 3'd0;
        cmd_imm_en = 1'b1;
        cmd_imm    = 16'h0042;
        @(posedge clk);
        #1;
        cmd_rd  = 3'd3;
        cmd_imm = 16'h0099;
        @(posedge clk);
        #1;
        held_data = 32'h0000_0042;
        for (int i = 0; i < 5; i++) begin
            check("t5.valid", 32'(rsp_valid), 32'd1);
            check("t5.data", rsp_data, held_data);
            check("t5.rd", 32'(rsp_rd), 32'd2);
            check("t5.cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5.released", 32'(rsp_valid), 32'd0);
        check("t5.cmd_ready", 32'(cmd_ready), 32'd1);
        check_reg("t5.r3_untouched", 3'd3, 32'h0000_000E);
        check_reg("t5.r2", 3'd2, 32'h0000_0042);

        // 6: reset during EXEC
        cmd_valid  = 1'b1;
        cmd_op     = 3'd0;
        cmd_rd     = 3'd1;
        cmd_rs     = 3'd0;
        cmd_imm_en = 1'b1;
        cmd_imm    = 16'h1234;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_reg("t6.exec_r1_old", 3'd1, 32'h0000_000F);
        rst_n = 1'b0;
        #1;
        check("t6.rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6.cmd_ready", 32'(cmd_ready), 32'd0);
        check("t6.alu_op", 32'(alu_op), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reg("t6.r1", 3'd1, 32'h0);
        check("t6.rsp_valid_after", 32'(rsp_valid), 32'd0);
        check("t6.cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("t6.alu_op_after", 32'(alu_op), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
